// File: rtl/bus_xbar.sv
// NumMaster x NumSlave bus crossbar: address decode, per-slave round-robin arbitration,
// response routing back to the issuing master, and an internal error responder for unmapped addresses.
module bus_xbar #(
  parameter int unsigned NumMaster = 2,
  parameter int unsigned NumSlave  = 8,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter logic [NumSlave-1:0][AW-1:0] SlaveBase = {
    32'h1000_5000, 32'h1000_4000, 32'h1000_3000, 32'h1000_2000,
    32'h1000_1000, 32'h1000_0000, 32'h0010_0000, 32'h0000_0000},
  parameter logic [NumSlave-1:0][AW-1:0] SlaveMask = {
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000}
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumMaster-1:0]              m_req_i,
  output logic [NumMaster-1:0]              m_gnt_o,
  input  logic [NumMaster-1:0][AW-1:0]      m_addr_i,
  input  logic [NumMaster-1:0]              m_we_i,
  input  logic [NumMaster-1:0][DW/8-1:0]    m_be_i,
  input  logic [NumMaster-1:0][DW-1:0]      m_wdata_i,
  output logic [NumMaster-1:0]              m_rvalid_o,
  output logic [NumMaster-1:0][DW-1:0]      m_rdata_o,
  output logic [NumMaster-1:0]              m_err_o,
  output logic [NumSlave-1:0]               s_req_o,
  output logic [NumSlave-1:0][AW-1:0]       s_addr_o,
  output logic [NumSlave-1:0]               s_we_o,
  output logic [NumSlave-1:0][DW/8-1:0]     s_be_o,
  output logic [NumSlave-1:0][DW-1:0]       s_wdata_o,
  input  logic [NumSlave-1:0]               s_gnt_i,
  input  logic [NumSlave-1:0]               s_rvalid_i,
  input  logic [NumSlave-1:0][DW-1:0]       s_rdata_i,
  input  logic [NumSlave-1:0]               s_err_i
);

  localparam int unsigned MW = (NumMaster > 1) ? $clog2(NumMaster) : 1;
  localparam int unsigned SW = (NumSlave > 1) ? $clog2(NumSlave) : 1;

  logic [NumMaster-1:0]         pending_q, pending_d;
  logic [NumMaster-1:0]         err_q, err_d;
  logic [NumSlave-1:0]          busy_q, busy_d;
  logic [NumSlave-1:0][MW-1:0]  owner_q, owner_d;
  logic [NumSlave-1:0][MW-1:0]  rr_q, rr_d;

  logic [NumMaster-1:0]         elig;
  logic [NumMaster-1:0]         hit;
  logic [NumMaster-1:0][SW-1:0] tgt;
  logic [NumSlave-1:0]          win_vld;
  logic [NumSlave-1:0][MW-1:0]  win_idx;

  // A master with a transaction in flight is invisible until its response has returned.
  assign elig = m_req_i & ~pending_q;

  // Address decode; scanning downwards lets the lowest matching slave win on overlap.
  always_comb begin
    hit = '0;
    tgt = '0;
    for (int m = 0; m < int'(NumMaster); m++) begin
      for (int s = int'(NumSlave) - 1; s >= 0; s--) begin
        if ((m_addr_i[m] & SlaveMask[s]) == SlaveBase[s]) begin
          hit[m] = 1'b1;
          tgt[m] = SW'(s);
        end
      end
    end
  end

  // Round-robin winner per idle slave, starting the search at rr_q.
  always_comb begin : arb
    int unsigned idx;
    idx     = 0;
    win_vld = '0;
    win_idx = '0;
    for (int s = 0; s < int'(NumSlave); s++) begin
      if (!busy_q[s]) begin
        for (int k = 0; k < int'(NumMaster); k++) begin
          idx = (32'(rr_q[s]) + 32'(k)) % NumMaster;
          if (!win_vld[s] && elig[MW'(idx)] && hit[MW'(idx)] && (tgt[MW'(idx)] == SW'(s))) begin
            win_vld[s] = 1'b1;
            win_idx[s] = MW'(idx);
          end
        end
      end
    end
  end

  // Forward the winner's request; everything stays zero without a winner.
  always_comb begin
    s_req_o   = win_vld;
    s_addr_o  = '0;
    s_we_o    = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    for (int s = 0; s < int'(NumSlave); s++) begin
      if (win_vld[s]) begin
        s_addr_o[s]  = m_addr_i[win_idx[s]];
        s_we_o[s]    = m_we_i[win_idx[s]];
        s_be_o[s]    = m_be_i[win_idx[s]];
        s_wdata_o[s] = m_wdata_i[win_idx[s]];
      end
    end
  end

  // Unmapped requests are accepted immediately by the error responder.
  always_comb begin
    err_d   = elig & ~hit;
    m_gnt_o = err_d;
    for (int s = 0; s < int'(NumSlave); s++) begin
      if (win_vld[s] && s_gnt_i[s]) m_gnt_o[win_idx[s]] = 1'b1;
    end
  end

  // Route responses to the recorded owner; responses from idle slaves are dropped.
  always_comb begin
    m_rvalid_o = err_q;
    m_err_o    = err_q;
    m_rdata_o  = '0;
    for (int m = 0; m < int'(NumMaster); m++) begin
      for (int s = 0; s < int'(NumSlave); s++) begin
        if (s_rvalid_i[s] && busy_q[s] && (owner_q[s] == MW'(m))) begin
          m_rvalid_o[m] = 1'b1;
          m_rdata_o[m]  = s_rdata_i[s];
          m_err_o[m]    = s_err_i[s];
        end
      end
    end
  end

  always_comb begin
    pending_d = pending_q;
    busy_d    = busy_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    for (int m = 0; m < int'(NumMaster); m++) begin
      if (m_rvalid_o[m])    pending_d[m] = 1'b0;
      else if (m_gnt_o[m])  pending_d[m] = 1'b1;
    end
    for (int s = 0; s < int'(NumSlave); s++) begin
      if (win_vld[s] && s_gnt_i[s]) begin
        busy_d[s]  = 1'b1;
        owner_d[s] = win_idx[s];
        rr_d[s]    = MW'((32'(win_idx[s]) + 32'd1) % NumMaster);
      end else if (s_rvalid_i[s]) begin
        busy_d[s]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      err_q     <= '0;
      busy_q    <= '0;
      owner_q   <= '0;
      rr_q      <= '0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
    end
  end

endmodule

// File: tb/tb_bus_xbar.sv
// Directed self-checking bench for bus_xbar with the default 2x8 memory map.
module tb_bus_xbar;
  localparam int unsigned NM = 2;
  localparam int unsigned NS = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic                       clk_i = 1'b0;
  logic                       rst_ni = 1'b0;
  logic [NM-1:0]              m_req_i;
  logic [NM-1:0]              m_gnt_o;
  logic [NM-1:0][AW-1:0]      m_addr_i;
  logic [NM-1:0]              m_we_i;
  logic [NM-1:0][DW/8-1:0]    m_be_i;
  logic [NM-1:0][DW-1:0]      m_wdata_i;
  logic [NM-1:0]              m_rvalid_o;
  logic [NM-1:0][DW-1:0]      m_rdata_o;
  logic [NM-1:0]              m_err_o;
  logic [NS-1:0]              s_req_o;
  logic [NS-1:0][AW-1:0]      s_addr_o;
  logic [NS-1:0]              s_we_o;
  logic [NS-1:0][DW/8-1:0]    s_be_o;
  logic [NS-1:0][DW-1:0]      s_wdata_o;
  logic [NS-1:0]              s_gnt_i;
  logic [NS-1:0]              s_rvalid_i;
  logic [NS-1:0][DW-1:0]      s_rdata_i;
  logic [NS-1:0]              s_err_i;

  int passed = 0;
  int total  = 0;

  bus_xbar dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o),
    .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .s_err_i(s_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs;
    m_req_i = '0; m_addr_i = '0; m_we_i = '0; m_be_i = '0; m_wdata_i = '0;
    s_gnt_i = '0; s_rvalid_i = '0; s_rdata_i = '0; s_err_i = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_ni = 1'b0;
    @(negedge clk_i);
    total++;
    if ({m_gnt_o, m_rvalid_o, m_err_o, s_req_o} !== '0)
      $display("FAIL reset_hold: gnt=%b rvalid=%b err=%b s_req=%b, required all 0", m_gnt_o, m_rvalid_o, m_err_o, s_req_o);
    else passed++;
    step();
    rst_ni = 1'b1;
    step();
    @(negedge clk_i);
    total++;
    if ({m_gnt_o, m_rvalid_o, m_err_o, s_req_o, m_rdata_o} !== '0)
      $display("FAIL reset_idle: gnt=%b rvalid=%b s_req=%b rdata=%h, required all 0", m_gnt_o, m_rvalid_o, s_req_o, m_rdata_o);
    else passed++;
    step();
  endtask

  task automatic test_read;
    m_req_i[0] = 1'b1; m_addr_i[0] = 32'h0010_0004; m_we_i[0] = 1'b0; m_be_i[0] = 4'hF;
    s_gnt_i[1] = 1'b1;
    @(negedge clk_i);
    total++;
    if (s_req_o !== 8'h02) $display("FAIL read_sreq: got %b required 00000010", s_req_o);
    else passed++;
    total++;
    if (m_gnt_o !== 2'b01) $display("FAIL read_gnt: got %b required 01", m_gnt_o);
    else passed++;
    total++;
    if (s_addr_o[1] !== 32'h0010_0004) $display("FAIL read_saddr: got %h required 00100004", s_addr_o[1]);
    else passed++;
    step();
    m_req_i[0] = 1'b0; s_gnt_i[1] = 1'b0;
    @(negedge clk_i);
    total++;
    if (m_rvalid_o !== 2'b00) $display("FAIL read_early_rvalid: got %b required 00", m_rvalid_o);
    else passed++;
    step();
    s_rvalid_i[1] = 1'b1; s_rdata_i[1] = 32'hDEAD_BEEF;
    @(negedge clk_i);
    total++;
    if (m_rvalid_o !== 2'b01 || m_rdata_o[0] !== 32'hDEAD_BEEF || m_err_o !== 2'b00)
      $display("FAIL read_resp: rvalid=%b rdata=%h err=%b required 01 deadbeef 00", m_rvalid_o, m_rdata_o[0], m_err_o);
    else passed++;
    step();
    s_rvalid_i[1] = 1'b0; s_rdata_i[1] = '0;
    @(negedge clk_i);
    total++;
    if (m_rvalid_o !== 2'b00 || m_rdata_o !== '0) $display("FAIL read_after: rvalid=%b rdata=%h required 0", m_rvalid_o, m_rdata_o);
    else passed++;
    do_reset();
  endtask

  task automatic test_contention;
    m_req_i = 2'b11; m_we_i = 2'b11; m_be_i[0] = 4'hF; m_be_i[1] = 4'hF;
    m_addr_i[0] = 32'h1000_1000; m_addr_i[1] = 32'h1000_1000;
    m_wdata_i[0] = 32'hAAAA_0000; m_wdata_i[1] = 32'hBBBB_1111;
    s_gnt_i[3] = 1'b1;
    @(negedge clk_i);
    total++;
    if (m_gnt_o !== 2'b01 || s_req_o !== 8'h08) $display("FAIL cont_first: gnt=%b s_req=%b required 01 00001000", m_gnt_o, s_req_o);
    else passed++;
    total++;
    if (s_wdata_o[3] !== 32'hAAAA_0000 || s_we_o[3] !== 1'b1) $display("FAIL cont_wdata0: wdata=%h we=%b required aaaa0000 1", s_wdata_o[3], s_we_o[3]);
    else passed++;
    step();
    m_req_i[0] = 1'b0; s_rvalid_i[3] = 1'b1;
    @(negedge clk_i);
    total++;
    if (m_rvalid_o !== 2'b01 || m_gnt_o !== 2'b00) $display("FAIL cont_resp0: rvalid=%b gnt=%b required 01 00", m_rvalid_o, m_gnt_o);
    else passed++;
    step();
    s_rvalid_i[3] = 1'b0;
    @(negedge clk_i);
    total++;
    if (m_gnt_o !== 2'b10 || s_wdata_o[3] !== 32'hBBBB_1111) $display("FAIL cont_second: gnt=%b wdata=%h required 10 bbbb1111", m_gnt_o, s_wdata_o[3]);
    else passed++;
    step();
    m_req_i[1] = 1'b0; s_rvalid_i[3] = 1'b1;
    @(negedge clk_i);
    total++;
    if (m_rvalid_o !== 2'b10) $display("FAIL cont_resp1: rvalid=%b required 10", m_rvalid_o);
    else passed++;
    step();
    s_rvalid_i[3] = 1'b0; m_req_i = 2'b11;
    @(negedge clk_i);
    total++;
    if (m_gnt_o !== 2'b01) $display("FAIL cont_rr_wrap: gnt=%b required 01", m_gnt_o);
    else passed++;
    do_reset();
  endtask

  task automatic test_unmapped;
    m_req_i[1] = 1'b1; m_addr_i[1] = 32'h2000_0000; m_we_i[1] = 1'b0;
    s_gnt_i = '1;
    @(negedge clk_i);
    total++;
    if (m_gnt_o !== 2'b10 || s_req_o !== 8'h00) $display("FAIL unmapped_gnt: gnt=%b s_req=%b required 10 00000000", m_gnt_o, s_req_o);
    else passed++;
    step();
    m_req_i[1] = 1'b0; s_gnt_i = '0;
    @(negedge clk_i);
    total++;
    if (m_rvalid_o !== 2'b10 || m_err_o !== 2'b10 || m_rdata_o[1] !== '0)
      $display("FAIL unmapped_resp: rvalid=%b err=%b rdata=%h required 10 10 0", m_rvalid_o, m_err_o, m_rdata_o[1]);
    else passed++;
    step();
    @(negedge clk_i);
    total++;
    if (m_rvalid_o !== 2'b00 || m_err_o !== 2'b00) $display("FAIL unmapped_after: rvalid=%b err=%b required 00 00", m_rvalid_o, m_err_o);
    else passed++;
    do_reset();
  endtask

  task automatic test_boundaries;
    logic [3:0][AW-1:0] addrs;
    logic [3:0][NS-1:0] exp_sreq;
    logic [3:0]         exp_gnt;
    addrs    = {32'h1000_5FFC, 32'h1000_0FFC, 32'h0001_0000, 32'h0000_FFFC};
    exp_sreq = {8'h80, 8'h04, 8'h00, 8'h01};
    exp_gnt  = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      m_req_i[0] = 1'b1; m_addr_i[0] = addrs[i];
      @(negedge clk_i);
      total++;
      if (s_req_o !== exp_sreq[i] || m_gnt_o[0] !== exp_gnt[i])
        $display("FAIL boundary_%0d: addr=%h s_req=%b gnt=%b required %b %b", i, addrs[i], s_req_o, m_gnt_o[0], exp_sreq[i], exp_gnt[i]);
      else passed++;
      step();
      m_req_i[0] = 1'b0;
      step();
      step();
    end
    do_reset();
  endtask

  task automatic test_parallel;
    m_req_i = 2'b11; m_we_i = 2'b00;
    m_addr_i[0] = 32'h0000_0010; m_addr_i[1] = 32'h1000_2000;
    s_gnt_i = 8'h11;
    @(negedge clk_i);
    total++;
    if (m_gnt_o !== 2'b11 || s_req_o !== 8'h11) $display("FAIL par_gnt: gnt=%b s_req=%b required 11 00010001", m_gnt_o, s_req_o);
    else passed++;
    total++;
    if (s_addr_o[4] !== 32'h1000_2000 || s_addr_o[0] !== 32'h0000_0010) $display("FAIL par_addr: s4=%h s0=%h required 10002000 00000010", s_addr_o[4], s_addr_o[0]);
    else passed++;
    step();
    m_req_i = '0; s_gnt_i = '0;
    s_rvalid_i[4] = 1'b1; s_rdata_i[4] = 32'h4444_4444; s_err_i[4] = 1'b1;
    @(negedge clk_i);
    total++;
    if (m_rvalid_o !== 2'b10 || m_err_o !== 2'b10 || m_rdata_o[1] !== 32'h4444_4444 || m_rdata_o[0] !== '0)
      $display("FAIL par_resp_m1: rvalid=%b err=%b rdata1=%h rdata0=%h required 10 10 44444444 0", m_rvalid_o, m_err_o, m_rdata_o[1], m_rdata_o[0]);
    else passed++;
    step();
    s_rvalid_i[4] = 1'b0; s_rdata_i[4] = '0; s_err_i[4] = 1'b0;
    s_rvalid_i[0] = 1'b1; s_rdata_i[0] = 32'h0000_1111;
    @(negedge clk_i);
    total++;
    if (m_rvalid_o !== 2'b01 || m_err_o !== 2'b00 || m_rdata_o[0] !== 32'h0000_1111)
      $display("FAIL par_resp_m0: rvalid=%b err=%b rdata0=%h required 01 00 00001111", m_rvalid_o, m_err_o, m_rdata_o[0]);
    else passed++;
    do_reset();
  endtask

  task automatic test_reset_midflight;
    m_req_i[0] = 1'b1; m_addr_i[0] = 32'h1000_4000; s_gnt_i[6] = 1'b1;
    @(negedge clk_i);
    total++;
    if (m_gnt_o !== 2'b01 || s_req_o !== 8'h40) $display("FAIL rst_mid_gnt: gnt=%b s_req=%b required 01 01000000", m_gnt_o, s_req_o);
    else passed++;
    step();
    m_req_i = '0; s_gnt_i = '0;
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    s_rvalid_i[6] = 1'b1; s_rdata_i[6] = 32'h6666_6666;
    m_req_i[1] = 1'b1; m_addr_i[1] = 32'h1000_4000;
    @(negedge clk_i);
    total++;
    if (m_rvalid_o !== 2'b00 || m_rdata_o !== '0) $display("FAIL rst_mid_late_rvalid: rvalid=%b rdata=%h required 00 0", m_rvalid_o, m_rdata_o);
    else passed++;
    total++;
    if (s_req_o !== 8'h40 || m_gnt_o !== 2'b00) $display("FAIL rst_mid_busy_clear: s_req=%b gnt=%b required 01000000 00", s_req_o, m_gnt_o);
    else passed++;
    do_reset();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_read();
    test_contention();
    test_unmapped();
    test_boundaries();
    test_parallel();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_xbar.md
# bus_xbar

- Parametrised NumMaster × NumSlave crossbar between the Ibex core's bus ports (instruction and data) and the SoC memories and peripherals.
- Decodes each master address against per-slave base/mask tables.
- Arbitrates each slave round-robin and routes responses back to the issuing master.
- Answers unmapped addresses with an internally generated error response.

## Interface
Parameters:
- NumMaster, 2, number of master ports
- NumSlave, 8, number of slave ports
- AW, 32, address width
- DW, 32, data width (byte-enable width DW/8)
- SlaveBase, [NumSlave][AW] = {0x0000_0000, 0x0010_0000, 0x1000_0000, 0x1000_1000, 0x1000_2000, 0x1000_3000, 0x1000_4000, 0x1000_5000}: region bases for instr RAM, data RAM, LED, UART, I2C, SPI, TIMER, SPI slave
- SlaveMask, [NumSlave][AW] = {0xFFFF_0000, 0xFFFF_0000, then 0xFFFF_F000 for all six peripherals}: region masks

Ports (all widths per port index; one clock, reset asynchronous active-low):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m_req_i  in  NumMaster  master request
- m_gnt_o  out  NumMaster  request accepted this cycle
- m_addr_i  in  NumMaster×AW  byte address
- m_we_i  in  NumMaster  write enable
- m_be_i  in  NumMaster×DW/8  byte enables
- m_wdata_i  in  NumMaster×DW  write data
- m_rvalid_o  out  NumMaster  response valid
- m_rdata_o  out  NumMaster×DW  read data
- m_err_o  out  NumMaster  response error
- s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o  out  NumSlave×(1/AW/1/DW/8/DW)  forwarded request
- s_gnt_i, s_rvalid_i, s_err_i  in  NumSlave  slave grant, response valid, error
- s_rdata_i  in  NumSlave×DW  slave read data

## Operation
- Decode: master m targets slave s when (m_addr_i & SlaveMask[s]) == SlaveBase[s].
  - On overlap, the lowest index wins.
  - No match: the target is the internal error responder.
- Per-master pending_q:
  - Set when m_gnt_o[m].
  - Cleared when m_rvalid_o[m].
  - While set, m_req_i[m] is masked, including the cycle its response returns.
  - Exactly one outstanding transaction per master.
- Per-slave busy_q[s] and owner_q[s]:
  - On s_req_o[s] & s_gnt_i[s]: busy_q←1, owner_q←granted master.
  - On s_rvalid_i[s]: busy_q←0.
  - s_req_o[s] = 0 while busy_q[s] (one outstanding per slave).
- Per-slave round-robin arbiter:
  - rr_q[s] holds the highest-priority master index.
  - Winner = first eligible requester at or after rr_q[s], cyclically.
  - On handshake, rr_q[s] ← winner+1 mod NumMaster.
  - rr_q[s] is unchanged if s_gnt_i[s] is low.
- Request path (combinational):
  - s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o are taken from the winner.
  - All are zero when there is no winner.
  - m_gnt_o[m] = s_gnt_i[s] when m is the winner of s.
- Error responder:
  - An unmapped eligible request is granted in the same cycle (m_gnt_o=1).
  - err_q[m] is set and produces the response the next cycle.
  - No s_req_o is driven.
- Response path:
  - m_rvalid_o[m] = err_q[m] OR any s_rvalid_i[s] with busy_q[s] & owner_q[s]==m.
  - rdata/err are muxed from that slave.
  - On the error path: rdata=0, err=1.
  - Outputs are zero when rvalid=0.
  - s_rvalid_i while !busy_q[s] is dropped.

## Timing
- Reset values:
  - All pending_q, busy_q, err_q = 0; rr_q = 0.
  - All outputs are 0 whenever no request is present.
- Request path is zero-latency combinational: m_req_i → s_req_o, s_gnt_i → m_gnt_o.
- Response latency is the slave's latency plus 0 cycles.
- Error response: rvalid exactly 1 cycle after the grant.
- Back-to-back from one master: the earliest new grant is the cycle after its rvalid.
- Masters targeting different slaves are granted in the same cycle.
- Reset asserted mid-transaction: all state is cleared immediately; in-flight responses are discarded (slaves are reset by the same rst_ni).
- m_addr_i/m_we_i/m_be_i/m_wdata_i must stay stable while m_req_i is high and ungranted. The crossbar does not register them.

## Test plan
- M0 reads 0x0010_0004, slave 1 gnt=1 and rvalid 2 cycles later with rdata 0xDEAD_BEEF:
  - s_req_o[1]=1 and m_gnt_o[0]=1 in the same cycle.
  - m_rvalid_o[0]=1, rdata=0xDEAD_BEEF, err=0, two cycles later.
- M0 and M1 both write UART 0x1000_1000 in the same cycle (s_gnt_i=1, rvalid +1):
  - M0 is granted first; M1 is granted the cycle after slave 3's rvalid.
  - Next contention: M0 is granted first again (rr_q[3] returned to 0 after M1's grant).
- M1 reads unmapped 0x2000_0000:
  - m_gnt_o[1]=1 in the same cycle; no s_req_o.
  - Next cycle m_rvalid_o[1]=1, err=1, rdata=0.
- Address boundaries:
  - 0x0000_FFFC → slave 0.
  - 0x0001_0000 → error.
  - 0x1000_0FFC → slave 2 (LED).
  - 0x1000_5FFC → slave 7.
- M0 → slave 0 and M1 → slave 4 in the same cycle: both granted; responses are independent and correctly routed. Slave err=1 propagates to m_err_o.
- Assert rst_ni while slave 6 is busy: busy_q cleared. A late s_rvalid_i[6] after reset release produces no m_rvalid_o.
